axi_stream_rx_buffer: RTL and testbench
=======================================

Name: axi_stream_rx_buffer

Overview:
- AXI4-Stream slave (receiver) endpoint. It accepts beats from an upstream master, buffers them in a small synchronous FIFO, and presents them on a simple show-ahead read port.
- Tracks per-packet byte length (TKEEP popcount) and a packet count for status/debug.
- Optionally checks the upstream master for handshake-rule violations in hardware.
- Sits at the edge of a stream consumer, e.g. in front of a register-mapped RX mailbox.

Parameters:
- byte_width, 4, TDATA width in bytes; must be at least 1.
- depth_log2, 4, FIFO depth is 2**depth_log2 beats.
- len_width, 16, width of the packet byte-length accumulator and result.
- cnt_width, 16, width of the completed-packet counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- resetn  in  1  reset, asynchronous assert, active-low.
- s_tvalid  in  1  upstream beat valid.
- s_tready  out  1  receiver can accept a beat.
- s_tdata  in  8*byte_width  beat payload.
- s_tkeep  in  byte_width  byte-valid qualifiers.
- s_tlast  in  1  last beat of packet.
- rd_valid  out  1  FIFO head is valid (FIFO not empty).
- rd_en  in  1  pop the FIFO head.
- rd_data  out  8*byte_width  head payload.
- rd_keep  out  byte_width  head TKEEP.
- rd_last  out  1  head TLAST.
- level  out  depth_log2+1  current FIFO occupancy.
- pkt_done  out  1  one-cycle pulse when a TLAST beat is accepted.
- pkt_len  out  len_width  byte length of the last completed packet.
- pkt_count  out  cnt_width  number of completed packets; wraps.
- proto_err  out  1  sticky upstream protocol violation.

Behaviour:
- Reset: asynchronous clear when resetn is low. Outputs go to s_tready=0, rd_valid=0, level=0, pkt_done=0, pkt_len=0, pkt_count=0, proto_err=0. FIFO pointers, byte accumulator and ready_en are also cleared.
- Ready sequencing: ready_en is a register set on the first rising edge with resetn high. s_tready = ready_en && !full. s_tready is derived only from registers, so there is no combinational path from s_tvalid.
- Accept condition: s_tvalid && s_tready. The beat {tdata, tkeep, tlast} is written at the tail; it is visible on rd_* the next cycle, so latency is 1 cycle.
- Pointers: depth_log2+1 bits with a wrap bit. Empty when the pointers are equal. Full when the low bits are equal and the wrap bits differ.
- Read port is show-ahead. rd_data/rd_keep/rd_last are valid whenever rd_valid=1. A pop happens on rd_en && rd_valid; rd_en while empty is ignored with no state change.
- Simultaneous push and pop: level is unchanged.
- At full: s_tready=0 even if a pop occurs in the same cycle. Ready recovers the next cycle.
- Byte accounting, on each accepted beat:
  - acc_next = acc + popcount(s_tkeep), saturating at 2**len_width-1.
  - A null beat (tkeep=0) is stored and counts 0 bytes.
  - If tlast: pkt_len <= acc_next, pkt_done <= 1 for one cycle, pkt_count <= pkt_count+1 (modulo 2**cnt_width), acc <= 0.
  - Otherwise acc <= acc_next.
- Reset mid-packet discards the partial accumulator and all buffered beats.

Optional Feature:
- Macro: AXIS_RX_PROTO_CHECK_EN.
- Defined: register the previous {s_tvalid, s_tready, s_tdata, s_tkeep, s_tlast}. proto_err is set and held until reset if either condition holds in a cycle after the first post-reset edge:
  - previous cycle had s_tvalid && !s_tready and s_tvalid is now 0, or
  - previous cycle had s_tvalid && !s_tready and any of tdata/tkeep/tlast changed.
- Not defined: proto_err is tied to 0 and the check registers are not instantiated.

Decomposition:
- Shared package/include axi_stream_defs:
  - popcount function parameterised on byte_width.
  - Beat-width constant 8*byte_width+byte_width+1.
  - Packed beat layout {tlast, tkeep, tdata}.
- Sub-module axi_stream_sync_fifo: storage array, pointers, full/empty/level, asynchronous active-low reset. The top level adds ready sequencing, accounting and the protocol checker.

Test Plan:
- Reset release, s_tvalid=1 held: s_tready=0 on the first post-reset cycle, 1 on the second; first beat accepted on the second cycle, rd_valid=1 one cycle later.
- 3-beat packet, tkeep=F,F,3, tlast on beat 3: pkt_done pulses once the cycle after beat 3; pkt_len=10, pkt_count=1; rd_* returns the beats in order with rd_last only on beat 3.
- Fill 16 beats with rd_en=0 (depth_log2=4): level=16, s_tready=0. rd_en=1 with s_tvalid=1: no accept that cycle, level=15, s_tready=1 next cycle.
- rd_en=1 while empty, plus a null beat tkeep=0 with tlast: no pop or underflow; pkt_len=0, pkt_count increments.
- With AXIS_RX_PROTO_CHECK_EN: stall (s_tready=0, s_tvalid=1), then change tdata 0xA5→0x5A while stalled: proto_err=1 next cycle and remains 1 until resetn=0. Without the macro, proto_err stays 0.
- Assert resetn=0 mid-packet after 2 beats, tkeep=F: all outputs clear immediately; after release, a 1-beat tkeep=1 tlast packet gives pkt_len=1.

Source files
------------

// File: rtl/axi_stream_defs.sv
// Shared definitions for the AXI4-Stream receive path: beat layout helpers and byte popcount.
package axi_stream_defs;

  // Widest TKEEP the popcount helper supports.
  localparam int unsigned keep_max = 64;

  // Packed beat layout is {tlast, tkeep, tdata}; total width in bits.
  function automatic int unsigned beat_width(input int unsigned byte_width);
    return 8 * byte_width + byte_width + 1;
  endfunction

  // Count set TKEEP bits among the low byte_width positions.
  function automatic logic [6:0] popcount(input logic [keep_max-1:0] keep,
                                          input int unsigned byte_width);
    logic [6:0] cnt;
    cnt = 7'd0;
    for (int i = 0; i < int'(keep_max); i++) begin
      if (i < int'(byte_width)) begin
        cnt = cnt + 7'(keep[i]);
      end
    end
    return cnt;
  endfunction

endpackage

// File: rtl/axi_stream_sync_fifo.sv
// Synchronous show-ahead FIFO with wrap-bit pointers and occupancy output.
module axi_stream_sync_fifo #(
  parameter int unsigned width      = 37,
  parameter int unsigned depth_log2 = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wr_en,
  input  logic [width-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [width-1:0]      rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [depth_log2:0]   level
);

  localparam int unsigned depth = 2 ** depth_log2;
  localparam int unsigned ptr_w = depth_log2 + 1;

  logic [width-1:0] mem_q [depth];
  logic [ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic             push, pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[depth_log2] != rd_ptr_q[depth_log2]) &&
                   (wr_ptr_q[depth_log2-1:0] == rd_ptr_q[depth_log2-1:0]);
  assign level   = wr_ptr_q - rd_ptr_q;
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem_q[rd_ptr_q[depth_log2-1:0]];

  // Pointer advance on accepted push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + ptr_w'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ptr_w'(1);
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset since empty gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[depth_log2-1:0]] <= wr_data;
  end

endmodule

// File: rtl/axi_stream_rx_buffer.sv
// AXI4-Stream receiver: buffers beats in a FIFO, tracks packet byte length and count.
// Optional upstream handshake checker enabled by defining AXIS_RX_PROTO_CHECK_EN.
module axi_stream_rx_buffer
  import axi_stream_defs::*;
#(
  parameter int unsigned byte_width = 4,
  parameter int unsigned depth_log2 = 4,
  parameter int unsigned len_width  = 16,
  parameter int unsigned cnt_width  = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic [8*byte_width-1:0] s_tdata,
  input  logic [byte_width-1:0]   s_tkeep,
  input  logic                    s_tlast,
  output logic                    rd_valid,
  input  logic                    rd_en,
  output logic [8*byte_width-1:0] rd_data,
  output logic [byte_width-1:0]   rd_keep,
  output logic                    rd_last,
  output logic [depth_log2:0]     level,
  output logic                    pkt_done,
  output logic [len_width-1:0]    pkt_len,
  output logic [cnt_width-1:0]    pkt_count,
  output logic                    proto_err
);

  localparam int unsigned data_w = 8 * byte_width;
  localparam int unsigned beat_w = beat_width(byte_width);

  logic                 ready_en_q, ready_en_d;
  logic [len_width-1:0] acc_q, acc_d;
  logic [len_width-1:0] pkt_len_q, pkt_len_d;
  logic [cnt_width-1:0] pkt_count_q, pkt_count_d;
  logic                 pkt_done_q, pkt_done_d;
  logic [beat_w-1:0]    wr_beat, rd_beat;
  logic                 fifo_full, fifo_empty, accept;
  logic [len_width:0]   acc_sum;
  logic [len_width-1:0] acc_next;

  assign wr_beat  = {s_tlast, s_tkeep, s_tdata};
  assign s_tready = ready_en_q && !fifo_full;
  assign accept   = s_tvalid && s_tready;

  axi_stream_sync_fifo #(
    .width      (beat_w),
    .depth_log2 (depth_log2)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (accept),
    .wr_data (wr_beat),
    .rd_en   (rd_en),
    .rd_data (rd_beat),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  assign rd_valid  = !fifo_empty;
  assign rd_data   = rd_beat[data_w-1:0];
  assign rd_keep   = rd_beat[data_w +: byte_width];
  assign rd_last   = rd_beat[beat_w-1];
  assign pkt_done  = pkt_done_q;
  assign pkt_len   = pkt_len_q;
  assign pkt_count = pkt_count_q;

  // Saturating byte accumulation for the current beat.
  always_comb begin
    acc_sum  = {1'b0, acc_q} + (len_width+1)'(popcount(keep_max'(s_tkeep), byte_width));
    acc_next = acc_sum[len_width] ? '1 : acc_sum[len_width-1:0];
  end

  // Ready sequencing and packet accounting next-state.
  always_comb begin
    ready_en_d  = 1'b1;
    acc_d       = acc_q;
    pkt_len_d   = pkt_len_q;
    pkt_count_d = pkt_count_q;
    pkt_done_d  = 1'b0;
    if (accept) begin
      if (s_tlast) begin
        pkt_len_d   = acc_next;
        pkt_done_d  = 1'b1;
        pkt_count_d = pkt_count_q + cnt_width'(1);
        acc_d       = '0;
      end else begin
        acc_d = acc_next;
      end
    end
  end

  // Accounting registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_en_q  <= 1'b0;
      acc_q       <= '0;
      pkt_len_q   <= '0;
      pkt_count_q <= '0;
      pkt_done_q  <= 1'b0;
    end else begin
      ready_en_q  <= ready_en_d;
      acc_q       <= acc_d;
      pkt_len_q   <= pkt_len_d;
      pkt_count_q <= pkt_count_d;
      pkt_done_q  <= pkt_done_d;
    end
  end

`ifdef AXIS_RX_PROTO_CHECK_EN
  logic              prev_stall_q, prev_stall_d;
  logic [beat_w-1:0] prev_beat_q, prev_beat_d;
  logic              proto_err_q, proto_err_d;

  // A stalled beat must stay valid and unchanged until accepted.
  always_comb begin
    prev_stall_d = s_tvalid && !s_tready;
    prev_beat_d  = wr_beat;
    proto_err_d  = proto_err_q;
    if (prev_stall_q && (!s_tvalid || (wr_beat != prev_beat_q))) begin
      proto_err_d = 1'b1;
    end
  end

  // Checker registers; error is sticky until reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prev_stall_q <= 1'b0;
      prev_beat_q  <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      prev_stall_q <= prev_stall_d;
      prev_beat_q  <= prev_beat_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign proto_err = proto_err_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_stream_rx_buffer.sv
// Bench for axi_stream_rx_buffer: directed vector table, corner sequences, random traffic vs queue model.
module tb_axi_stream_rx_buffer;

  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        resetn;
  logic        s_tvalid, s_tready;
  logic [31:0] s_tdata;
  logic [3:0]  s_tkeep;
  logic        s_tlast;
  logic        rd_valid, rd_en;
  logic [31:0] rd_data;
  logic [3:0]  rd_keep;
  logic        rd_last;
  logic [4:0]  level;
  logic        pkt_done;
  logic [15:0] pkt_len, pkt_count;
  logic        proto_err;

  always #5 clk = ~clk;

  axi_stream_rx_buffer dut (
    .clk(clk), .resetn(resetn),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .rd_valid(rd_valid), .rd_en(rd_en), .rd_data(rd_data),
    .rd_keep(rd_keep), .rd_last(rd_last), .level(level),
    .pkt_done(pkt_done), .pkt_len(pkt_len), .pkt_count(pkt_count),
    .proto_err(proto_err)
  );

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  // Transaction-level reference state.
  beat_t       q[$];
  bit          m_ren, m_done, m_perr, m_prev_stall;
  beat_t       m_prev;
  int unsigned m_acc, m_len, m_cnt;

  typedef struct {
    logic v; logic [31:0] d; logic [3:0] k; logic l; logic r;
    logic e_rdy; logic e_rv; logic [31:0] e_d; logic e_l;
    int e_lvl; logic e_done; int e_len; int e_cnt;
  } vec_t;
  vec_t vt[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ren = 0; m_done = 0; m_perr = 0; m_prev_stall = 0; m_prev = '0;
    m_acc = 0; m_len = 0; m_cnt = 0;
  endtask

  task automatic compare_model();
    beat_t h;
    chk("m_s_tready", 64'(s_tready), 64'(m_ren && (q.size() < DEPTH)));
    chk("m_rd_valid", 64'(rd_valid), 64'(q.size() != 0));
    chk("m_level", 64'(level), 64'(q.size()));
    if (q.size() != 0) begin
      h = q[0];
      chk("m_rd_data", 64'(rd_data), 64'(h.data));
      chk("m_rd_keep", 64'(rd_keep), 64'(h.keep));
      chk("m_rd_last", 64'(rd_last), 64'(h.last));
    end
    chk("m_pkt_done", 64'(pkt_done), 64'(m_done));
    chk("m_pkt_len", 64'(pkt_len), 64'(m_len));
    chk("m_pkt_count", 64'(pkt_count), 64'(m_cnt));
    chk("m_proto_err", 64'(proto_err), 64'(m_perr));
  endtask

  // One clock: predict from current inputs, advance, then compare.
  task automatic tick();
    beat_t cur;
    bit rdy, acc, pop;
    int unsigned a;
    cur = '{data: s_tdata, keep: s_tkeep, last: s_tlast};
    rdy = m_ren && (q.size() < DEPTH);
    acc = s_tvalid && rdy;
    pop = rd_en && (q.size() != 0);
`ifdef AXIS_RX_PROTO_CHECK_EN
    if (m_prev_stall && (!s_tvalid || cur != m_prev)) m_perr = 1;
    m_prev_stall = s_tvalid && !rdy;
    m_prev = cur;
`endif
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(cur);
    m_done = 0;
    if (acc) begin
      a = m_acc + $countones(cur.keep);
      if (a > 65535) a = 65535;
      if (cur.last) begin
        m_len = a; m_done = 1; m_cnt = (m_cnt + 1) % 65536; m_acc = 0;
      end else begin
        m_acc = a;
      end
    end
    m_ren = 1;
    #1;
    compare_model();
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] k,
                       input logic l, input logic r);
    s_tvalid = v; s_tdata = d; s_tkeep = k; s_tlast = l; rd_en = r;
  endtask

  initial begin
    bit pending;
    logic exp_perr;

    drive(0, 0, 0, 0, 0);
    resetn = 0;
    model_reset();

    // Reset release with a beat already offered; 3-beat packet; empty pop; null beat.
    vt[0] = '{1, 32'hAAAA0001, 4'hF, 0, 0,  1, 0, 32'h0,        0, 0, 0, 0,  0};
    vt[1] = '{1, 32'hAAAA0001, 4'hF, 0, 0,  1, 1, 32'hAAAA0001, 0, 1, 0, 0,  0};
    vt[2] = '{1, 32'hBBBB0002, 4'hF, 0, 0,  1, 1, 32'hAAAA0001, 0, 2, 0, 0,  0};
    vt[3] = '{1, 32'hCCCC0003, 4'h3, 1, 0,  1, 1, 32'hAAAA0001, 0, 3, 1, 10, 1};
    vt[4] = '{0, 32'h0,        4'h0, 0, 1,  1, 1, 32'hBBBB0002, 0, 2, 0, 10, 1};
    vt[5] = '{0, 32'h0,        4'h0, 0, 1,  1, 1, 32'hCCCC0003, 1, 1, 0, 10, 1};
    vt[6] = '{0, 32'h0,        4'h0, 0, 1,  1, 0, 32'h0,        0, 0, 0, 10, 1};
    vt[7] = '{1, 32'hDDDD0004, 4'h0, 1, 1,  1, 1, 32'hDDDD0004, 1, 1, 1, 0,  2};
    vt[8] = '{0, 32'h0,        4'h0, 0, 1,  1, 0, 32'h0,        0, 0, 0, 0,  2};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_pkt_done", 64'(pkt_done), 64'd0);
    chk("rst_pkt_len", 64'(pkt_len), 64'd0);
    chk("rst_pkt_count", 64'(pkt_count), 64'd0);
    chk("rst_proto_err", 64'(proto_err), 64'd0);

    resetn = 1;
    drive(vt[0].v, vt[0].d, vt[0].k, vt[0].l, vt[0].r);
    #1;
    chk("release_s_tready", 64'(s_tready), 64'd0);

    for (int i = 0; i < 9; i++) begin
      drive(vt[i].v, vt[i].d, vt[i].k, vt[i].l, vt[i].r);
      tick();
      chk($sformatf("vec%0d_s_tready", i), 64'(s_tready), 64'(vt[i].e_rdy));
      chk($sformatf("vec%0d_rd_valid", i), 64'(rd_valid), 64'(vt[i].e_rv));
      if (vt[i].e_rv) begin
        chk($sformatf("vec%0d_rd_data", i), 64'(rd_data), 64'(vt[i].e_d));
        chk($sformatf("vec%0d_rd_last", i), 64'(rd_last), 64'(vt[i].e_l));
      end
      chk($sformatf("vec%0d_level", i), 64'(level), 64'(vt[i].e_lvl));
      chk($sformatf("vec%0d_pkt_done", i), 64'(pkt_done), 64'(vt[i].e_done));
      chk($sformatf("vec%0d_pkt_len", i), 64'(pkt_len), 64'(vt[i].e_len));
      chk($sformatf("vec%0d_pkt_count", i), 64'(pkt_count), 64'(vt[i].e_cnt));
    end

    // Fill to full, then pop at full: no accept that cycle.
    for (int i = 0; i < 16; i++) begin
      drive(1, 32'h1000 + 32'(i), 4'hF, (i == 15), 0);
      tick();
    end
    chk("full_level", 64'(level), 64'd16);
    chk("full_s_tready", 64'(s_tready), 64'd0);
    drive(1, 32'hFEED0000, 4'hF, 1, 1);
    tick();
    chk("popfull_level", 64'(level), 64'd15);
    chk("popfull_s_tready", 64'(s_tready), 64'd1);
    drive(1, 32'hFEED0000, 4'hF, 1, 0);
    tick();
    chk("refill_level", 64'(level), 64'd16);

    // Stall then change payload while stalled.
    drive(1, 32'hA5, 4'hF, 0, 0);
    tick();
    drive(1, 32'h5A, 4'hF, 0, 0);
    tick();
`ifdef AXIS_RX_PROTO_CHECK_EN
    exp_perr = 1'b1;
`else
    exp_perr = 1'b0;
`endif
    chk("proto_err_set", 64'(proto_err), 64'(exp_perr));
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 17; i++) tick();
    chk("proto_err_sticky", 64'(proto_err), 64'(exp_perr));

    // Reset mid-packet after two beats.
    drive(1, 32'h22220001, 4'hF, 0, 0);
    tick();
    drive(1, 32'h22220002, 4'hF, 0, 0);
    tick();
    resetn = 0;
    #1;
    chk("midrst_s_tready", 64'(s_tready), 64'd0);
    chk("midrst_rd_valid", 64'(rd_valid), 64'd0);
    chk("midrst_level", 64'(level), 64'd0);
    chk("midrst_pkt_count", 64'(pkt_count), 64'd0);
    chk("midrst_pkt_len", 64'(pkt_len), 64'd0);
    chk("midrst_proto_err", 64'(proto_err), 64'd0);
    model_reset();
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1;
    drive(1, 32'h00000011, 4'h1, 1, 0);
    tick();
    tick();
    drive(0, 0, 0, 0, 0);
    chk("postrst_pkt_done", 64'(pkt_done), 64'd1);
    chk("postrst_pkt_len", 64'(pkt_len), 64'd1);
    chk("postrst_pkt_count", 64'(pkt_count), 64'd1);

    // Random compliant traffic with phases biased toward filling and draining.
    for (int n = 0; n < 3000; n++) begin
      pending = s_tvalid && !(m_ren && (q.size() < DEPTH));
      if (!pending) begin
        s_tvalid = ($urandom_range(0, 9) < 7);
        s_tdata  = $urandom;
        s_tkeep  = 4'($urandom);
        s_tlast  = ($urandom_range(0, 3) == 0);
      end
      rd_en = (((n / 200) % 2) == 0) ? ($urandom_range(0, 3) == 0)
                                     : ($urandom_range(0, 3) != 0);
      tick();
    end

    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) tick();
    chk("final_empty", 64'(rd_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
